// File: rtl/pong_pkg.sv
// Shared definitions for the pong datapath: ball FSM state encoding,
// default playfield size and coordinate width. Used by pong_ball,
// spaceship and the renderer so all agree on widths and encodings.
package pong_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned FIELD_W = 640;
  localparam int unsigned FIELD_H = 480;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_MISS  = 2'd2,
    ST_OVER  = 2'd3
  } ball_state_t;

endpackage

// File: rtl/pong_ball.sv
// pong_ball: ball motion, wall/paddle collision and serve/miss/game-over FSM.
// All updates happen on a frame tick (i_animate & i_ani_stb) except the
// o_miss clear, which happens on the following clock.
//
// Ports:
//   i_clk                        system clock
//   i_rst                        asynchronous active-low reset
//   i_ani_stb, i_animate         pixel strobe / end-of-frame flag (tick = both)
//   i_serve                      serve / restart request (level)
//   i_pad_x1, i_pad_x2, i_pad_y1 paddle box edges
//   o_x1, o_x2, o_y1, o_y2       registered ball box edges
//   o_state                      FSM state (SERVE/PLAY/MISS/OVER)
//   o_lives                      remaining lives
//   o_hits                       saturating paddle-hit count
//   o_miss                       one-clock pulse when the ball is missed
module pong_ball
  import pong_pkg::*;
#(
  parameter int unsigned H_SIZE      = 4,
  parameter int unsigned IX          = 320,
  parameter int unsigned IY          = 240,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned D_WIDTH     = FIELD_W,
  parameter int unsigned D_HEIGHT    = FIELD_H,
  parameter int unsigned MISS_FRAMES = 60
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ani_stb,
  input  logic               i_animate,
  input  logic               i_serve,
  input  logic [COORD_W-1:0] i_pad_x1,
  input  logic [COORD_W-1:0] i_pad_x2,
  input  logic [COORD_W-1:0] i_pad_y1,
  output logic [COORD_W-1:0] o_x1,
  output logic [COORD_W-1:0] o_x2,
  output logic [COORD_W-1:0] o_y1,
  output logic [COORD_W-1:0] o_y2,
  output logic [1:0]         o_state,
  output logic [1:0]         o_lives,
  output logic [7:0]         o_hits,
  output logic               o_miss
);

  localparam int unsigned CNT_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

  // One extra bit so sums near the field edge cannot wrap.
  typedef logic [COORD_W:0] ext_t;

  localparam coord_t HS    = coord_t'(H_SIZE);
  localparam coord_t SPD   = coord_t'(SPEED);
  localparam coord_t X0    = coord_t'(IX);
  localparam coord_t Y0    = coord_t'(IY);
  localparam coord_t X_MIN = coord_t'(H_SIZE);
  localparam coord_t X_MAX = coord_t'(D_WIDTH - 1 - H_SIZE);
  localparam coord_t Y_MIN = coord_t'(H_SIZE);

  localparam ext_t HS_E    = ext_t'(H_SIZE);
  localparam ext_t SPD_E   = ext_t'(SPEED);
  localparam ext_t X_MAX_E = ext_t'(D_WIDTH - 1 - H_SIZE);
  localparam ext_t FLOOR_E = ext_t'(D_HEIGHT - 1);
  // "pos - SPEED <= H_SIZE" rewritten as "pos <= H_SIZE + SPEED" to avoid underflow.
  localparam ext_t LO_BOUNCE_E = ext_t'(H_SIZE + SPEED);

  localparam logic [CNT_W-1:0] MISS_LAST = CNT_W'(MISS_FRAMES - 1);

  ball_state_t      state;
  coord_t           x, y;
  logic             dx_right, dy_down;
  logic             serve_right;
  logic [CNT_W-1:0] miss_cnt;

  logic   tick;
  coord_t x_nxt, y_nxt;
  logic   dx_nxt, dy_nxt;
  logic   hit_left, hit_right, hit_top, pad_hit, floor_miss;
  ext_t   x_e, y_e, bot_e;

  assign tick    = i_animate & i_ani_stb;
  assign o_state = state;

  // Next-position logic for PLAY; x and y rules are independent.
  always_comb begin
    x_e        = {1'b0, x};
    y_e        = {1'b0, y};
    bot_e      = y_e + HS_E;
    hit_left   = !dx_right && (x_e <= LO_BOUNCE_E);
    hit_right  = dx_right && (x_e + SPD_E >= X_MAX_E);
    hit_top    = !dy_down && (y_e <= LO_BOUNCE_E);
    pad_hit    = dy_down
                 && (bot_e <= {1'b0, i_pad_y1})
                 && (bot_e + SPD_E >= {1'b0, i_pad_y1})
                 && (x_e + HS_E > {1'b0, i_pad_x1})
                 && (x_e < {1'b0, i_pad_x2} + HS_E);
    floor_miss = dy_down && !pad_hit && (bot_e + SPD_E >= FLOOR_E);

    x_nxt  = dx_right ? x + SPD : x - SPD;
    dx_nxt = dx_right;
    if (hit_left) begin
      x_nxt  = X_MIN;
      dx_nxt = 1'b1;
    end else if (hit_right) begin
      x_nxt  = X_MAX;
      dx_nxt = 1'b0;
    end

    y_nxt  = dy_down ? y + SPD : y - SPD;
    dy_nxt = dy_down;
    if (hit_top) begin
      y_nxt  = Y_MIN;
      dy_nxt = 1'b1;
    end else if (pad_hit) begin
      y_nxt  = i_pad_y1 - HS;
      dy_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= ST_SERVE;
      x           <= X0;
      y           <= Y0;
      dx_right    <= 1'b1;
      dy_down     <= 1'b0;
      serve_right <= 1'b1;
      miss_cnt    <= '0;
      o_lives     <= 2'd3;
      o_hits      <= '0;
      o_miss      <= 1'b0;
      o_x1        <= X0 - HS;
      o_x2        <= X0 + HS;
      o_y1        <= Y0 - HS;
      o_y2        <= Y0 + HS;
    end else begin
      o_miss <= 1'b0;
      o_x1   <= x - HS;
      o_x2   <= x + HS;
      o_y1   <= y - HS;
      o_y2   <= y + HS;
      if (tick) begin
        unique case (state)
          ST_SERVE: begin
            x       <= X0;
            y       <= Y0;
            dy_down <= 1'b0;
            if (i_serve) begin
              state       <= ST_PLAY;
              dx_right    <= serve_right;
              serve_right <= !serve_right;
            end
          end
          ST_PLAY: begin
            x        <= x_nxt;
            dx_right <= dx_nxt;
            // On a miss y stays where it was; the ball freezes from here.
            if (floor_miss) begin
              state    <= ST_MISS;
              o_lives  <= o_lives - 2'd1;
              o_miss   <= 1'b1;
              miss_cnt <= '0;
            end else begin
              y       <= y_nxt;
              dy_down <= dy_nxt;
              if (pad_hit && (o_hits != 8'hFF)) o_hits <= o_hits + 8'd1;
            end
          end
          ST_MISS: begin
            if (miss_cnt == MISS_LAST) begin
              miss_cnt <= '0;
              if (o_lives == 2'd0) begin
                state <= ST_OVER;
              end else begin
                state   <= ST_SERVE;
                x       <= X0;
                y       <= Y0;
                dy_down <= 1'b0;
              end
            end else begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
          ST_OVER: begin
            if (i_serve) begin
              state   <= ST_SERVE;
              o_lives <= 2'd3;
              o_hits  <= '0;
              x       <= X0;
              y       <= Y0;
              dy_down <= 1'b0;
            end
          end
          default: state <= ST_SERVE;
        endcase
      end
    end
  end

endmodule
